// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared states, grant ids, default widths and a saturating counter helper
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_e;
  function automatic logic [31:0] sat_inc(logic [31:0] v, logic [1:0] n);
    logic [32:0] s;
    s = {1'b0, v} + 33'(n);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache, data and shared memory valid/ready buses
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              i_valid, i_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_valid, d_ready;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin selector; bit GNT_I is icache, bit GNT_D is data
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);
  gnt_e last_q, last_d;
  always_comb begin
    gnt_o  = (&req_i) ? (last_q == GNT_D ? 2'b01 : 2'b10) : req_i;
    last_d = (adv_i && |req_i) ? (gnt_o[GNT_D] ? GNT_D : GNT_I) : last_q;
  end
  // last_grant resets to data so the first contended grant favours the icache
  always_ff @(posedge clk) last_q <= !resetn ? GNT_D : last_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin icache/data arbiter onto one memory port, one grant outstanding.
// Defining MEM_ARB_STATS_EN adds saturating debug counters (grants, conflicts, wait cycles).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] dbg_i_grants,
  output logic [31:0] dbg_d_grants,
  output logic [31:0] dbg_conflicts,
  output logic [31:0] dbg_wait_cycles
`endif
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, i_rdata_q, d_rdata_q;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]          gnt;
  logic                idle;
  assign idle = state_q == IDLE;
  rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req_i  ({bus.d_valid, bus.i_valid}),
    .adv_i  (idle),
    .gnt_o  (gnt)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (idle && gnt[GNT_I]) begin
      state_d = BUSY_I;
      addr_d  = bus.i_addr;
      wdata_d = '0;
      wstrb_d = '0;
    end else if (idle && gnt[GNT_D]) begin
      state_d = BUSY_D;
      addr_d  = bus.d_addr;
      wdata_d = bus.d_wdata;
      wstrb_d = bus.d_wstrb;
    end else if (!idle && bus.mem_ready) begin
      state_d = IDLE;
    end
  end
  // each requester's rdata holds its last delivered word outside its ready pulse
  assign bus.mem_valid = !idle;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.i_ready   = state_q == BUSY_I && bus.mem_ready;
  assign bus.d_ready   = state_q == BUSY_D && bus.mem_ready;
  assign bus.i_rdata   = bus.i_ready ? bus.mem_rdata : i_rdata_q;
  assign bus.d_rdata   = bus.d_ready ? bus.mem_rdata : d_rdata_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      i_rdata_q <= bus.i_rdata;
      d_rdata_q <= bus.d_rdata;
    end
  end
`ifdef MEM_ARB_STATS_EN
  logic [1:0] waits;
  assign waits = 2'(bus.i_valid && state_q != BUSY_I) + 2'(bus.d_valid && state_q != BUSY_D);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dbg_i_grants    <= '0;
      dbg_d_grants    <= '0;
      dbg_conflicts   <= '0;
      dbg_wait_cycles <= '0;
    end else begin
      dbg_i_grants    <= sat_inc(dbg_i_grants, 2'(idle && gnt[GNT_I]));
      dbg_d_grants    <= sat_inc(dbg_d_grants, 2'(idle && gnt[GNT_D]));
      dbg_conflicts   <= sat_inc(dbg_conflicts, 2'(idle && bus.i_valid && bus.d_valid));
      dbg_wait_cycles <= sat_inc(dbg_wait_cycles, waits);
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench; inputs driven 1 unit after posedge, outputs sampled on negedge
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    gnt_e        port;
  } mreq_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
`ifdef MEM_ARB_STATS_EN
  logic [31:0] dbg_i_grants, dbg_d_grants, dbg_conflicts, dbg_wait_cycles;
`endif
  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .dbg_i_grants    (dbg_i_grants),
    .dbg_d_grants    (dbg_d_grants),
    .dbg_conflicts   (dbg_conflicts),
    .dbg_wait_cycles (dbg_wait_cycles)
`endif
  );

  mreq_t       exp_mem[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  time         t_d[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          lat = 0;
  bit          tie = 1'b0;
  gnt_e        cur = GNT_I;
  logic        prev_mv = 1'b0;
  int          tb_wait = 0;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_rdy(bit d);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (d ? bus.d_ready : bus.i_ready) break;
    end
    if (k == 60) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no %s_ready within 60 cycles", d ? "d" : "i");
    end
  endtask

  task automatic req_i(logic [31:0] a, bit hold);
    @(posedge clk); #1;
    bus.i_valid = 1'b1;
    bus.i_addr  = a;
    wait_rdy(1'b0);
    if (!hold) begin
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
    end
  endtask

  task automatic req_d(logic [31:0] a, logic [31:0] wd, logic [3:0] ws, bit hold);
    @(posedge clk); #1;
    bus.d_valid = 1'b1;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_wstrb = ws;
    wait_rdy(1'b1);
    if (!hold) begin
      @(posedge clk); #1;
      bus.d_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  // memory model: ready after lat wait cycles, or permanently high when tie is set
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (tie) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_data(bus.mem_addr);
      end else if (bus.mem_valid && !bus.mem_ready) begin
        if (cnt >= lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_data(bus.mem_addr);
        end else cnt++;
      end else begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // monitor: checks each new memory request and each ready pulse against the queues
  initial begin
    mreq_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_valid && !prev_mv) begin
        if (exp_mem.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL grant: unexpected memory request addr %h", bus.mem_addr);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_wdata", bus.mem_wdata, e.wdata);
          chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
          cur = e.port;
        end
      end
      if (bus.i_ready) begin
        if (exp_i.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL i_ready: unexpected pulse rdata %h", bus.i_rdata);
        end else chk("i_rdata", bus.i_rdata, exp_i.pop_front());
        chk("i_ready exclusive of d_ready", 32'(bus.d_ready), 32'd0);
      end
      if (bus.d_ready) begin
        t_d.push_back($time);
        if (exp_d.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL d_ready: unexpected pulse rdata %h", bus.d_rdata);
        end else chk("d_rdata", bus.d_rdata, exp_d.pop_front());
      end
      tb_wait = !resetn ? 0 : tb_wait + int'(bus.i_valid && !(bus.mem_valid && cur == GNT_I))
                                      + int'(bus.d_valid && !(bus.mem_valid && cur == GNT_D));
      prev_mv = bus.mem_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_addr  = '0;
    bus.d_valid = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;
    repeat (2) @(negedge clk);
    chk("reset mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("reset i_ready", 32'(bus.i_ready), 32'd0);
    chk("reset d_ready", 32'(bus.d_ready), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    // mem_ready high while idle must not produce any pulse or request
    @(negedge clk) tie = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle mem_ready ignored i_ready", 32'(bus.i_ready), 32'd0);
    chk("idle mem_ready ignored d_ready", 32'(bus.d_ready), 32'd0);
    chk("idle mem_valid", 32'(bus.mem_valid), 32'd0);
    tie = 1'b0;
    repeat (2) @(negedge clk);
    // single icache read, 3-cycle memory; data-side fields are garbage and must not leak
    lat = 2;
    exp_mem.push_back('{32'h100, 32'h0, 4'h0, GNT_I});
    exp_i.push_back(32'hDEADBEEF);
    @(posedge clk); #1;
    bus.d_wdata = 32'hCAFEF00D;
    bus.d_wstrb = 4'hF;
    bus.i_valid = 1'b1;
    bus.i_addr  = 32'h100;
    @(negedge clk);
    chk("mem_valid before grant", 32'(bus.mem_valid), 32'd0);
    @(negedge clk);
    chk("mem_valid one cycle after i_valid", 32'(bus.mem_valid), 32'd1);
    wait_rdy(1'b0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("i_ready single cycle", 32'(bus.i_ready), 32'd0);
    chk("i_rdata held", bus.i_rdata, 32'hDEADBEEF);
    // data write
    lat = 1;
    exp_mem.push_back('{32'h2000, 32'h12345678, 4'b0011, GNT_D});
    exp_d.push_back(32'hA5A5_2000);
    req_d(32'h2000, 32'h12345678, 4'b0011, 1'b0);
    @(negedge clk);
    chk("mem_valid drops after write", 32'(bus.mem_valid), 32'd0);
    // contended after reset: I,D,I,D
    do_reset();
    lat = 0;
    exp_mem.push_back('{32'h300, 32'h0, 4'h0, GNT_I});
    exp_mem.push_back('{32'h400, 32'hAAAA0000, 4'h0, GNT_D});
    exp_mem.push_back('{32'h304, 32'h0, 4'h0, GNT_I});
    exp_mem.push_back('{32'h404, 32'hAAAA0000, 4'h0, GNT_D});
    exp_i.push_back(32'hA5A5_0300);
    exp_i.push_back(32'hA5A5_0304);
    exp_d.push_back(32'hA5A5_0400);
    exp_d.push_back(32'hA5A5_0404);
    fork
      begin req_i(32'h300, 1'b1); req_i(32'h304, 1'b0); end
      begin req_d(32'h400, 32'hAAAA0000, 4'h0, 1'b1); req_d(32'h404, 32'hAAAA0000, 4'h0, 1'b0); end
    join
    chk("contended grants consumed", 32'(exp_mem.size()), 32'd0);
    // back-to-back data reads, mem_ready tied high: one completion every 2 cycles
    @(negedge clk) tie = 1'b1;
    t_d.delete();
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back('{32'h500 + 32'(4 * i), 32'h0, 4'h0, GNT_D});
      exp_d.push_back(32'hA5A5_0500 + 32'(4 * i));
    end
    for (int i = 0; i < 4; i++) req_d(32'h500 + 32'(4 * i), 32'h0, 4'h0, i != 3);
    @(negedge clk) tie = 1'b0;
    chk("b2b completions", 32'(t_d.size()), 32'd4);
    if (t_d.size() == 4) begin
      chk("b2b spacing", 32'(t_d[1] - t_d[0]), 32'd20);
      chk("b2b total", 32'(t_d[3] - t_d[0]), 32'd60);
    end
    // reset while BUSY_D drops the transaction
    lat = 20;
    exp_mem.push_back('{32'h600, 32'h55, 4'hF, GNT_D});
    @(posedge clk); #1;
    bus.d_valid = 1'b1;
    bus.d_addr  = 32'h600;
    bus.d_wdata = 32'h55;
    bus.d_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    chk("busy_d mem_valid", 32'(bus.mem_valid), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("reset is synchronous", 32'(bus.mem_valid), 32'd1);
    @(negedge clk);
    chk("mid reset mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("mid reset mem_addr", bus.mem_addr, 32'd0);
    chk("mid reset mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.d_valid = 1'b0;
    @(negedge clk);
    chk("after reset no request", 32'(bus.mem_valid), 32'd0);
    lat = 1;
    exp_mem.push_back('{32'h604, 32'h66, 4'h1, GNT_D});
    exp_d.push_back(32'hA5A5_0604);
    req_d(32'h604, 32'h66, 4'h1, 1'b0);
`ifdef MEM_ARB_STATS_EN
    do_reset();
    for (int p = 0; p < 3; p++) begin
      exp_mem.push_back('{32'h700 + 32'(8 * p), 32'h0, 4'h0, GNT_I});
      exp_mem.push_back('{32'h800 + 32'(8 * p), 32'(p), 4'h1, GNT_D});
      exp_i.push_back(32'hA5A5_0700 + 32'(8 * p));
      exp_d.push_back(32'hA5A5_0800 + 32'(8 * p));
      fork
        req_i(32'h700 + 32'(8 * p), 1'b0);
        req_d(32'h800 + 32'(8 * p), 32'(p), 4'h1, 1'b0);
      join
    end
    repeat (3) @(negedge clk);
    chk("dbg_conflicts", dbg_conflicts, 32'd3);
    chk("dbg_i_grants", dbg_i_grants, 32'd3);
    chk("dbg_d_grants", dbg_d_grants, 32'd3);
    chk("dbg_wait_cycles", dbg_wait_cycles, 32'(tb_wait));
`endif
    repeat (2) @(negedge clk);
    chk("pending mem requests", 32'(exp_mem.size()), 32'd0);
    chk("pending i responses", 32'(exp_i.size()), 32'd0);
    chk("pending d responses", 32'(exp_d.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
